// File: rtl/core_divider_if.sv
// Handshake bundle for the restoring divider: operand request side and result side.
interface core_divider_if #(
  parameter int DW = 4
);
  localparam int NW = 2 * DW;

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/core_divider.sv
// Sequential restoring divider: NW-bit dividend / DW-bit divisor, one quotient bit per clock,
// valid/ready on both sides.
module core_divider #(
  parameter int DW = 4
) (
  input logic          clk,
  input logic          rst_n,
  core_divider_if.slave bus
);
  localparam int NW = 2 * DW;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [NW-1:0] quotient_r;
  logic [DW-1:0] remainder_r;
  logic          dz_r;

  logic [DW:0]   rem_w;
  logic [NW-1:0] quo_w;
  logic [DW-1:0] dvs;

  logic          accept;
  logic [DW+1:0] shifted;
  logic [DW+1:0] trial;
  logic          q_bit;
  logic [DW:0]   rem_nxt;
  logic [NW-1:0] quo_nxt;

  function automatic logic [DW+1:0] trial_sub(input logic [DW+1:0] pr, input logic [DW-1:0] d);
    return pr - {2'b00, d};
  endfunction

  assign accept = bus.in_valid & in_ready_r;

  // quo_w doubles as the dividend shifter: dividend bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    shifted = {rem_w, quo_w[NW-1]};
    trial   = trial_sub(shifted, dvs);
    q_bit   = ~trial[DW+1];
    rem_nxt = q_bit ? trial[DW:0] : shifted[DW:0];
    quo_nxt = {quo_w[NW-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      rem_w <= '0;
      quo_w <= bus.dividend;
      dvs   <= bus.divisor;
    end else if (state == BUSY) begin
      rem_w <= rem_nxt;
      quo_w <= quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_r <= 1'b0;
            cnt        <= CW'(NW - 1);
            if (bus.divisor == '0) begin
              state       <= DONE;
              quotient_r  <= '1;
              remainder_r <= '0;
              dz_r        <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            quotient_r  <= quo_nxt;
            remainder_r <= rem_nxt[DW-1:0];
            dz_r        <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // divide-by-zero enters DONE straight from IDLE; out_valid rises one edge later
          if (out_valid_r && bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_core_divider.sv
// Self-checking bench for core_divider: directed cases, a multiply/divide round-trip sweep
// and random operations against a plain-arithmetic reference.
module tb_core_divider;
  localparam int DW = 4;
  localparam int NW = 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  core_divider_if #(.DW(DW)) bus ();

  core_divider #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = (1 << NW) - 1;
      r = 0;
      dz = 1;
    end else begin
      q = a / b;
      r = a % b;
      dz = 0;
    end
  endfunction

  task automatic run_op(input int a, input int b, input int eq, input int er, input int edz,
                        input int hold, input string tag);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.dividend  = NW'(a);
    bus.divisor   = DW'(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = NW'($urandom);
    bus.divisor  = DW'($urandom);
    chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (edz != 0) ? 32'd1 : 32'(NW));
    chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = NW'($urandom);
      bus.divisor  = DW'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_q"}, 32'(bus.quotient), 32'(eq));
      chk({tag, "_hold_r"}, 32'(bus.remainder), 32'(er));
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int q;
    int r;
    int dz;
    int a;
    int b;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(143, 11, 13, 0, 0, 0, "exact");
    run_op(200, 15, 13, 5, 0, 0, "rem200");
    run_op(255, 1, 255, 0, 0, 0, "div1");
    run_op(7, 9, 0, 7, 0, 0, "small");
    run_op(77, 0, 255, 0, 1, 0, "dz");
    run_op(100, 7, 14, 2, 0, 5, "bp");

    // abort 250/3 after four iterations
    bus.dividend = 8'd250;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_q", 32'(bus.quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(250, 3, 83, 1, 0, 0, "after_abort");

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        run_op(ai * bi, bi, ai, 0, 0, 0, "sweep");
      end
    end

    for (int k = 0; k < 150; k++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      ref_div(a, b, q, r, dz);
      run_op(a, b, q, r, dz, int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
